// File: rtl/twiddle_seq.sv
// Twiddle-factor ROM address sequencer for the radix-2 DIF FFT.
// Walks k over one or more stages and tags the ROM's registered output.
module twiddle_seq #(
   parameter int unsigned N_LOG2 = 10,
   parameter int unsigned ADDR_W = N_LOG2 - 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        stage,
   input  logic              all_stages,
   input  logic              hold,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_ce,
   output logic              tw_valid,
   output logic [N_LOG2-2:0] tw_idx,
   output logic [3:0]        tw_stage,
   output logic              tw_last,
   output logic              busy,
   output logic              done,
   output logic              cfg_err
);

   localparam int unsigned KW = N_LOG2 - 1;
   localparam int unsigned SW = 4;
   localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
   localparam logic [SW-1:0] S_LIM  = SW'(N_LOG2);
   localparam logic [SW-1:0] S_MAX  = SW'(N_LOG2 - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [SW-1:0] s_q, s_d;
   logic [SW-1:0] last_s_q, last_s_d;
   logic          tw_valid_q, tw_valid_d;
   logic [KW-1:0] tw_idx_q, tw_idx_d;
   logic [SW-1:0] tw_stage_q, tw_stage_d;
   logic          tw_last_q, tw_last_d;
   logic          done_q, done_d;
   logic          cfg_err_q, cfg_err_d;
   logic          rom_ce_c;

   // Next-state, index walk and tag load; tags share the ROM enable
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      s_d        = s_q;
      last_s_d   = last_s_q;
      tw_valid_d = tw_valid_q;
      tw_idx_d   = tw_idx_q;
      tw_stage_d = tw_stage_q;
      tw_last_d  = tw_last_q;
      done_d     = 1'b0;
      cfg_err_d  = 1'b0;
      rom_ce_c   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (stage < S_LIM) begin
                  k_d      = '0;
                  s_d      = stage;
                  last_s_d = all_stages ? S_MAX : stage;
                  state_d  = RUN;
               end else begin
                  cfg_err_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (!hold) begin
               rom_ce_c   = 1'b1;
               tw_valid_d = 1'b1;
               tw_idx_d   = k_q;
               tw_stage_d = s_q;
               tw_last_d  = (k_q == K_LAST);
               if (k_q != K_LAST) begin
                  k_d = k_q + KW'(1);
               end else begin
                  k_d = '0;
                  // Next stage starts on the very next edge, no bubble
                  if (s_q < last_s_q) s_d = s_q + SW'(1);
                  else                state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (!hold) begin
               tw_valid_d = 1'b0;
               tw_last_d  = 1'b0;
               done_d     = 1'b1;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         k_q        <= '0;
         s_q        <= '0;
         last_s_q   <= '0;
         tw_valid_q <= 1'b0;
         tw_idx_q   <= '0;
         tw_stage_q <= '0;
         tw_last_q  <= 1'b0;
         done_q     <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         k_q        <= k_d;
         s_q        <= s_d;
         last_s_q   <= last_s_d;
         tw_valid_q <= tw_valid_d;
         tw_idx_q   <= tw_idx_d;
         tw_stage_q <= tw_stage_d;
         tw_last_q  <= tw_last_d;
         done_q     <= done_d;
         cfg_err_q  <= cfg_err_d;
      end
   end

   // Low ADDR_W bits of k * 2^s
   assign rom_addr = ADDR_W'(k_q << s_q);
   assign rom_ce   = rom_ce_c;
   assign busy     = (state_q != IDLE);
   assign tw_valid = tw_valid_q;
   assign tw_idx   = tw_idx_q;
   assign tw_stage = tw_stage_q;
   assign tw_last  = tw_last_q;
   assign done     = done_q;
   assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// Bench for twiddle_seq: queue-based element model, golden twiddle ROM,
// per-cycle compare process plus directed run scenarios.
module tb_twiddle_seq;

   logic        clk, rst, start, all_stages, hold;
   logic [3:0]  stage;
   logic [8:0]  rom_addr;
   logic        rom_ce, tw_valid, tw_last, busy, done, cfg_err;
   logic [8:0]  tw_idx;
   logic [3:0]  tw_stage;
   logic [17:0] rom_dout;

   twiddle_seq dut (
      .clk(clk), .rst(rst), .start(start), .stage(stage),
      .all_stages(all_stages), .hold(hold), .rom_addr(rom_addr),
      .rom_ce(rom_ce), .tw_valid(tw_valid), .tw_idx(tw_idx),
      .tw_stage(tw_stage), .tw_last(tw_last), .busy(busy),
      .done(done), .cfg_err(cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { int k; int s; } elem_t;
   elem_t iss_q[$];
   elem_t cons_q[$];

   int n_vec = 0;
   int n_err = 0;
   int n_consumed = 0;
   int n_out = 0;
   bit done_due = 0;
   bit chk_en = 0;

   function automatic int addr_of(input int k, input int s);
      return (k * (1 << s)) % 512;
   endfunction

   function automatic logic [17:0] rom_val(input int a);
      return 18'(a * 1237 + 91);
   endfunction

   // Golden twiddle ROM with registered, enable-gated output
   always @(posedge clk) if (rom_ce) rom_dout <= rom_val(int'(rom_addr));

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the element queues
   always @(negedge clk) begin
      elem_t e;
      if (!chk_en) begin
         done_due = 0;
         n_out = 0;
      end else begin
         chk("busy", int'(busy), int'(cons_q.size() != 0));
         chk("done", int'(done), int'(done_due));
         done_due = 0;
         chk("tw_valid", int'(tw_valid), int'(n_out > 0));
         chk("rom_ce", int'(rom_ce), int'(iss_q.size() != 0 && !hold));
         if (rom_ce && iss_q.size() != 0) begin
            e = iss_q.pop_front();
            chk("rom_addr", int'(rom_addr), addr_of(e.k, e.s));
            n_out++;
         end
         if (tw_valid && !hold && cons_q.size() != 0) begin
            e = cons_q.pop_front();
            chk("tw_idx", int'(tw_idx), e.k);
            chk("tw_stage", int'(tw_stage), e.s);
            chk("tw_last", int'(tw_last), int'(e.k == 511));
            chk("rom_dout", int'(rom_dout), int'(rom_val(addr_of(e.k, e.s))));
            n_out--;
            n_consumed++;
            if (cons_q.size() == 0) done_due = 1;
         end
      end
   end

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_rom_ce"}, int'(rom_ce), 0);
      chk({tag, "_rom_addr"}, int'(rom_addr), 0);
      chk({tag, "_tw_valid"}, int'(tw_valid), 0);
      chk({tag, "_tw_idx"}, int'(tw_idx), 0);
      chk({tag, "_tw_stage"}, int'(tw_stage), 0);
      chk({tag, "_tw_last"}, int'(tw_last), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_cfg_err"}, int'(cfg_err), 0);
   endtask

   // One accepted run; returns early if abort_idx of stage stg is reached
   task automatic run(input int stg, input bit all, input int hold_pct,
                      input bit poke, input int abort_idx);
      int  n0, cyc, nst, last;
      bit  seen_done;
      last = all ? 9 : stg;
      nst  = last - stg + 1;
      hold = 1'b0;
      stage = 4'(stg);
      all_stages = all;
      start = 1'b1;
      n0 = n_consumed;
      @(posedge clk); #1;
      start = 1'b0;
      all_stages = 1'b0;
      for (int s = stg; s <= last; s++)
         for (int k = 0; k < 512; k++) begin
            iss_q.push_back('{k, s});
            cons_q.push_back('{k, s});
         end
      if (hold_pct == 0) begin
         chk("first_busy", int'(busy), 1);
         chk("first_ce", int'(rom_ce), 1);
         chk("first_addr", int'(rom_addr), 0);
      end
      cyc = 0;
      seen_done = 0;
      while (!seen_done && cyc < 8000) begin
         hold = (hold_pct > 0) && ($urandom_range(99) < hold_pct);
         if (poke && cyc == 100) begin
            start = 1'b1;
            stage = 4'd5;
            all_stages = 1'b1;
         end else begin
            start = 1'b0;
            all_stages = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
         if (done) seen_done = 1;
         if (abort_idx >= 0 && tw_valid && int'(tw_idx) == abort_idx &&
             int'(tw_stage) == stg) begin
            hold = 1'b0;
            start = 1'b0;
            return;
         end
      end
      hold = 1'b0;
      start = 1'b0;
      chk("done_seen", int'(seen_done), 1);
      chk("elements", n_consumed - n0, 512 * nst);
      if (hold_pct == 0) chk("latency", cyc, 512 * nst + 1);
      chk("busy_at_done", int'(busy), 0);
   endtask

   task automatic bad_start(input int stg);
      stage = 4'(stg);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("cfg_err_pulse", int'(cfg_err), 1);
      chk("cfg_err_busy", int'(busy), 0);
      @(posedge clk); #1;
      chk("cfg_err_clear", int'(cfg_err), 0);
      chk("cfg_err_busy2", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      stage = 4'd0;
      all_stages = 1'b0;
      hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_reset("idle");
      chk_en = 1;

      // Hand-computed address pins for the model
      chk("pin_s3_k1", addr_of(1, 3), 8);
      chk("pin_s3_k63", addr_of(63, 3), 504);
      chk("pin_s3_k64", addr_of(64, 3), 0);
      chk("pin_s3_k511", addr_of(511, 3), 504);
      chk("pin_s9_k1", addr_of(1, 9), 0);
      chk("pin_s2_k200", addr_of(200, 2), 288);

      run(0, 0, 0, 0, -1);
      run(3, 0, 0, 1, -1);
      run(9, 0, 0, 0, -1);
      run(7, 1, 0, 0, -1);
      bad_start(10);
      bad_start(15);
      run(2, 0, 30, 0, -1);

      // Mid-run reset at k=200 of stage 1, then a clean restart
      run(1, 0, 0, 0, 200);
      chk_en = 0;
      rst = 1'b1;
      @(posedge clk); #1;
      chk_reset("midrst");
      rst = 1'b0;
      iss_q.delete();
      cons_q.delete();
      @(posedge clk); #1;
      chk_reset("postrst");
      chk_en = 1;
      run(1, 0, 0, 0, -1);

      repeat (3) @(posedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
